stamp_activity_ctrl: RTL and testbench
======================================

STAMP_ACTIVITY_CTRL -- requirements
Module: stamp_activity_ctrl

Interface
REQ-001 The block SHALL have parameter PWM_BITS, default 8, width of the duty-cycle level and PWM counter.
REQ-002 The block SHALL have parameter XOR_PERIOD, default 16, cycles between signature-capture strobes in RUN (legal range 2..65535).
REQ-003 The block SHALL have parameter RAMP_STEP_CYCLES, default 256, cycles per one-LSB level step during ramps (legal range 1..65535).
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: i_clk  in  1  clock; i_rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have i_start  in  1  single-cycle start request.
REQ-006 The block SHALL have i_stop  in  1  single-cycle stop request.
REQ-007 The block SHALL have i_level  in  PWM_BITS  target duty, giving i_level/2^PWM_BITS.
REQ-008 The block SHALL have o_ena  out  1  activity enable to the downstream stamp array.
REQ-009 The block SHALL have o_xor_ena  out  1  signature-capture strobe to the stamp array.
REQ-010 The block SHALL have o_output_ena  out  1  output-register enable to the stamp array.
REQ-011 The block SHALL have o_state  out  2  current FSM state encoding.
REQ-012 The block SHALL have o_busy  out  1  high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE=0, RAMP_UP=1, RUN=2, RAMP_DOWN=3; all outputs SHALL be registered.
REQ-014 In IDLE, i_start=1 with i_stop=0 SHALL latch i_level into target and enter RAMP_UP on the next edge, with cur_level=0, pwm_cnt=0, step_cnt=0.
REQ-015 i_start SHALL be ignored in all states except IDLE, and i_level SHALL be sampled only at that accepted start.
REQ-016 i_start and i_stop high together in IDLE SHALL leave the FSM in IDLE (stop wins).
REQ-017 pwm_cnt SHALL increment by 1 each cycle in any non-IDLE state, wrap from 2^PWM_BITS-1 to 0, and be held at 0 in IDLE.
REQ-018 o_ena SHALL be registered as (pwm_cnt < cur_level) using unsigned compare, and SHALL be 0 in IDLE.
REQ-019 cur_level=0 SHALL give o_ena constantly 0, and cur_level=2^PWM_BITS-1 SHALL give o_ena low exactly 1 cycle per PWM period.
REQ-020 In RAMP_UP and RAMP_DOWN, step_cnt SHALL count 0..RAMP_STEP_CYCLES-1 and wrap to 0; at the wrap, cur_level SHALL increment (RAMP_UP) or decrement (RAMP_DOWN) by 1.
REQ-021 RAMP_UP SHALL go to RUN on the edge after cur_level==target, including the case target=0, where RUN is entered one cycle after entering RAMP_UP.
REQ-022 RAMP_DOWN SHALL go to IDLE on the edge after cur_level==0, and cur_level SHALL never underflow or exceed target.
REQ-023 i_stop in RAMP_UP or RUN SHALL enter RAMP_DOWN on the next edge, with step_cnt cleared and cur_level kept at its current value.
REQ-024 i_stop SHALL be ignored in RAMP_DOWN and IDLE.
REQ-025 In RUN, xor_cnt SHALL count 0..XOR_PERIOD-1 and wrap, and o_xor_ena SHALL be 1 for exactly one cycle per period, when xor_cnt==XOR_PERIOD-1.
REQ-026 xor_cnt SHALL be 0 on RUN entry, so the first strobe occurs XOR_PERIOD cycles after entry; o_xor_ena SHALL be 0 outside RUN.
REQ-027 o_output_ena SHALL be 1 exactly while the state is RUN.
REQ-028 o_state SHALL equal the state encoding, o_busy SHALL equal (state!=IDLE), and both SHALL update on the same edge as the transition.

Reset
REQ-029 On i_rst=1 at a rising i_clk edge, state, target, cur_level, pwm_cnt, step_cnt and xor_cnt SHALL all become 0.
REQ-030 On that reset, o_ena, o_xor_ena, o_output_ena, o_busy and o_state SHALL all become 0.
REQ-031 Reset SHALL override i_start and i_stop in the same cycle and SHALL abort any ramp or run immediately, without a ramp-down.
REQ-032 The block SHALL have no asynchronous reset path.

Verification
REQ-033 Defaults, i_level=4, start pulse -> RAMP_UP for 4*256+1 cycles, then RUN; o_ena high 4 of every 256 cycles; o_xor_ena pulses every 16 cycles in RUN, first at 16 cycles after entry.
REQ-034 i_level=0, start -> RUN one cycle after RAMP_UP entry, o_ena never 1; stop -> RAMP_DOWN -> IDLE within 2 cycles.
REQ-035 i_level=255, RAMP_STEP_CYCLES=1 -> RUN after 256 cycles; o_ena low exactly once per 256 cycles.
REQ-036 Stop pulse at cur_level=2 during RAMP_UP (target 8) -> RAMP_DOWN, level 2->1->0 at 256-cycle steps, then IDLE; o_output_ena never 1.
REQ-037 Start and stop together in IDLE -> stays IDLE; start pulse in RUN -> no effect; i_level changed in RUN -> duty unchanged.
REQ-038 i_rst pulse mid-RUN -> next edge: every output 0 and o_state=0; a following start behaves as from power-up.

Source files
------------

// File: rtl/stamp_activity_ctrl.sv
// rtl/stamp_activity_ctrl.sv - PWM activity controller with level ramps and signature strobes for a stamp array
module stamp_activity_ctrl #(
  parameter int PWM_BITS         = 8,
  parameter int XOR_PERIOD       = 16,
  parameter int RAMP_STEP_CYCLES = 256
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [PWM_BITS-1:0] i_level,
  output logic                o_ena,
  output logic                o_xor_ena,
  output logic                o_output_ena,
  output logic [1:0]          o_state,
  output logic                o_busy
);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RAMP_UP   = 2'd1;
  localparam logic [1:0] ST_RUN       = 2'd2;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

  // Terminal counts; both counters are 16 bits to cover the full parameter range.
  localparam logic [15:0] STEP_LAST = 16'(RAMP_STEP_CYCLES - 1);
  localparam logic [15:0] XOR_LAST  = 16'(XOR_PERIOD - 1);

  logic [1:0]          state;
  logic [1:0]          state_nx;
  logic [PWM_BITS-1:0] target;
  logic [PWM_BITS-1:0] cur_level;
  logic [PWM_BITS-1:0] cur_level_nx;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [15:0]         step_cnt;
  logic [15:0]         step_cnt_nx;
  logic [15:0]         xor_cnt;
  logic                step_wrap;

  assign step_wrap = (step_cnt == STEP_LAST);
  assign o_state   = state;

  // Next state, ramp level and step counter; stop takes priority over ramp progress.
  always_comb begin
    state_nx     = state;
    cur_level_nx = cur_level;
    step_cnt_nx  = '0;
    case (state)
      ST_IDLE: begin
        cur_level_nx = '0;
        if (i_start && !i_stop) begin
          state_nx = ST_RAMP_UP;
        end
      end
      ST_RAMP_UP: begin
        if (i_stop) begin
          state_nx = ST_RAMP_DOWN;
        end else if (cur_level == target) begin
          state_nx = ST_RUN;
        end else begin
          step_cnt_nx = step_wrap ? '0 : step_cnt + 16'(1);
          if (step_wrap) begin
            cur_level_nx = cur_level + PWM_BITS'(1);
          end
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_nx = ST_RAMP_DOWN;
        end
      end
      ST_RAMP_DOWN: begin
        if (cur_level == '0) begin
          state_nx = ST_IDLE;
        end else begin
          step_cnt_nx = step_wrap ? '0 : step_cnt + 16'(1);
          if (step_wrap) begin
            cur_level_nx = cur_level - PWM_BITS'(1);
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; outputs are gated by the next state so
  // that nothing from the old state leaks across a transition into IDLE or out of RUN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state        <= ST_IDLE;
      target       <= '0;
      cur_level    <= '0;
      pwm_cnt      <= '0;
      step_cnt     <= '0;
      xor_cnt      <= '0;
      o_ena        <= 1'b0;
      o_xor_ena    <= 1'b0;
      o_output_ena <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_level <= cur_level_nx;
      step_cnt  <= step_cnt_nx;
      if (state == ST_IDLE && state_nx == ST_RAMP_UP) begin
        target <= i_level;
      end
      if (state != ST_IDLE && state_nx != ST_IDLE) begin
        pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end else begin
        pwm_cnt <= '0;
      end
      if (state == ST_RUN && state_nx == ST_RUN) begin
        xor_cnt <= (xor_cnt == XOR_LAST) ? '0 : xor_cnt + 16'(1);
      end else begin
        xor_cnt <= '0;
      end
      o_ena        <= (state != ST_IDLE) && (state_nx != ST_IDLE) && (pwm_cnt < cur_level);
      o_xor_ena    <= (state == ST_RUN) && (state_nx == ST_RUN) && (xor_cnt == XOR_LAST);
      o_output_ena <= (state_nx == ST_RUN);
      o_busy       <= (state_nx != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_stamp_activity_ctrl.sv
// tb/tb_stamp_activity_ctrl.sv - randomized model-checked bench for stamp_activity_ctrl
module tb_stamp_activity_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] level_a;
  logic [7:0] level_b;
  logic       ena_o  [2];
  logic       xor_o  [2];
  logic       oe_o   [2];
  logic       busy_o [2];
  logic [1:0] st_o   [2];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  stamp_activity_ctrl #(.PWM_BITS(8), .XOR_PERIOD(16), .RAMP_STEP_CYCLES(256)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_level(level_a),
    .o_ena(ena_o[0]), .o_xor_ena(xor_o[0]), .o_output_ena(oe_o[0]),
    .o_state(st_o[0]), .o_busy(busy_o[0])
  );

  stamp_activity_ctrl #(.PWM_BITS(8), .XOR_PERIOD(5), .RAMP_STEP_CYCLES(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop), .i_level(level_b),
    .o_ena(ena_o[1]), .o_xor_ena(xor_o[1]), .o_output_ena(oe_o[1]),
    .o_state(st_o[1]), .o_busy(busy_o[1])
  );

  function automatic int ramp_of(input int k);
    return (k == 0) ? 256 : 1;
  endfunction

  function automatic int period_of(input int k);
    return (k == 0) ? 16 : 5;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%0d required=%0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: mode, level, time spent in the current phase and time busy.
  int m_st  [2];
  int m_lvl [2];
  int m_tgt [2];
  int m_tph [2];
  int m_tbz [2];
  int e_ena [2];
  int e_xor [2];
  bit armed = 1'b0;

  always @(posedge clk) begin : model
    int ps, pl, ptp, ptb, ns, lv, rp, pr;
    for (int k = 0; k < 2; k++) begin
      ps = m_st[k]; pl = m_lvl[k]; ptp = m_tph[k]; ptb = m_tbz[k];
      lv = (k == 0) ? int'(level_a) : int'(level_b);
      rp = ramp_of(k); pr = period_of(k);
      if (rst) begin
        m_st[k] = 0; m_lvl[k] = 0; m_tgt[k] = 0; m_tph[k] = 0; m_tbz[k] = 0;
        e_ena[k] = 0; e_xor[k] = 0;
      end else begin
        ns = ps;
        case (ps)
          0: if (start && !stop) begin ns = 1; m_tgt[k] = lv; m_lvl[k] = 0; m_tph[k] = 0; end
          1: begin
            if (stop) begin ns = 3; m_tph[k] = 0; end
            else if (pl == m_tgt[k]) begin ns = 2; m_tph[k] = 0; end
            else begin
              m_tph[k] = ptp + 1;
              if (m_tph[k] % rp == 0) m_lvl[k] = pl + 1;
            end
          end
          2: begin
            if (stop) begin ns = 3; m_tph[k] = 0; end
            else m_tph[k] = ptp + 1;
          end
          default: begin
            if (pl == 0) begin ns = 0; m_tph[k] = 0; end
            else begin
              m_tph[k] = ptp + 1;
              if (m_tph[k] % rp == 0) m_lvl[k] = pl - 1;
            end
          end
        endcase
        m_tbz[k] = (ps != 0 && ns != 0) ? ptb + 1 : 0;
        e_ena[k] = (ps != 0 && ns != 0 && (ptb % 256) < pl) ? 1 : 0;
        e_xor[k] = (ps == 2 && ns == 2 && (ptp % pr) == pr - 1) ? 1 : 0;
        m_st[k]  = ns;
      end
    end
    if (rst) armed = 1'b1;
  end

  // Every-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        chk("state", k, int'(st_o[k]), m_st[k]);
        chk("busy", k, int'(busy_o[k]), (m_st[k] != 0) ? 1 : 0);
        chk("output_ena", k, int'(oe_o[k]), (m_st[k] == 2) ? 1 : 0);
        chk("ena", k, int'(ena_o[k]), e_ena[k]);
        chk("xor_ena", k, int'(xor_o[k]), e_xor[k]);
      end
    end
  end

  task automatic wait_idle(input int lim, output int ok);
    ok = 0;
    for (int n = 0; n < lim; n++) begin
      if (st_o[0] == 2'd0 && st_o[1] == 2'd0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int cnt_a, cnt_b, ok, hi_a, lo_b, first;
    rst = 1'b1; start = 1'b0; stop = 1'b0; level_a = 8'd0; level_b = 8'd0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_state", k, int'(st_o[k]), 0);
      chk("reset_ena", k, int'(ena_o[k]), 0);
    end

    // Level 4 on defaults, level 255 with one-cycle steps.
    rst = 1'b0; level_a = 8'd4; level_b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0; level_a = 8'd200; level_b = 8'd17;
    cnt_a = 0; cnt_b = 0; ok = 0;
    for (int n = 0; n < 2000; n++) begin
      if (st_o[0] == 2'd2) begin
        ok = 1;
        break;
      end
      if (st_o[0] == 2'd1) cnt_a++;
      if (st_o[1] == 2'd1) cnt_b++;
      @(negedge clk);
    end
    chk("run_reached", 0, ok, 1);
    chk("ramp_up_len", 0, cnt_a, 1025);
    chk("ramp_up_len", 1, cnt_b, 256);
    hi_a = 0; lo_b = 0; first = -1;
    for (int n = 0; n < 256; n++) begin
      if (ena_o[0]) hi_a++;
      if (!ena_o[1]) lo_b++;
      if (xor_o[0] && first < 0) first = n;
      @(negedge clk);
    end
    chk("duty_high", 0, hi_a, 4);
    chk("duty_low", 1, lo_b, 1);
    chk("first_xor", 0, first, 16);

    // Start in RUN with a new level has no effect.
    level_a = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hi_a = 0;
    for (int n = 0; n < 256; n++) begin
      if (ena_o[0]) hi_a++;
      @(negedge clk);
    end
    chk("duty_after_start", 0, hi_a, 4);
    chk("still_run", 0, int'(st_o[0]), 2);

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_idle(3000, ok);
    chk("ramp_down_idle", 0, ok, 1);

    // Start and stop together in IDLE.
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_idle", 0, int'(st_o[0]), 0);
    chk("start_stop_idle", 1, int'(st_o[1]), 0);

    // Stop during ramp-up at level 2 of 8.
    level_a = 8'd8; level_b = 8'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (600) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_in_ramp", 0, int'(st_o[0]), 3);
    wait_idle(3000, ok);
    chk("ramp_down_from_2", 0, ok, 1);

    // Level 0: RUN one cycle after RAMP_UP entry.
    level_a = 8'd0; level_b = 8'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_ramp_entry", 0, int'(st_o[0]), 1);
    @(negedge clk);
    chk("zero_run", 0, int'(st_o[0]), 2);
    chk("zero_run", 1, int'(st_o[1]), 2);
    repeat (40) @(negedge clk);

    // Reset in RUN clears everything at once.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_run_state", k, int'(st_o[k]), 0);
      chk("rst_run_busy", k, int'(busy_o[k]), 0);
      chk("rst_run_oe", k, int'(oe_o[k]), 0);
      chk("rst_run_xor", k, int'(xor_o[k]), 0);
      chk("rst_run_ena", k, int'(ena_o[k]), 0);
    end

    // Randomized traffic: long runs first, then frequent stops.
    for (int n = 0; n < 30000; n++) begin
      start   = ($urandom_range(0, 39) == 0);
      stop    = ($urandom_range(0, (n < 15000) ? 1999 : 59) == 0);
      rst     = ($urandom_range(0, 4999) == 0);
      level_a = 8'($urandom_range(0, 5));
      level_b = 8'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
